acc_window_avg: RTL

//  Window controller/averager wrapped around the Q8.12 accumulator stage. Accepts Q4.12 samples
//  on a valid/ready input, drives the accumulator's data_en/data_in, and counts accepted samples.

---
 rtl/acc_window_avg.sv | 117 +++++++++++
 1 files changed

// File: rtl/acc_window_avg.sv
// Window controller/averager around an external Q8.12 accumulator: counts 2^LOG2N Q4.12 samples,
// then emits the rounded, saturated window mean on a valid/ready output.
module acc_window_avg #(
  parameter int unsigned LOG2N = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic        flush,
  output logic        acc_en,
  output logic [15:0] acc_din,
  output logic        acc_rst,
  input  logic [19:0] acc_sum,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_partial
);

  localparam int unsigned WinLen = 1 << LOG2N;
  localparam int unsigned CntW   = LOG2N + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WinLen - 1);
  // Half an LSB of the divided result; zero when the window is a single sample.
  localparam logic signed [20:0] Rnd = 21'((1 << LOG2N) >> 1);

  localparam logic [0:0] StAccum = 1'b0;
  localparam logic [0:0] StDump  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic            partial_q, partial_d;

  logic            accept;
  logic            slot_free;
  logic            dump_fire;

  logic signed [20:0] rnd_sum;
  logic signed [20:0] shifted;
  logic [15:0]        mean_sat;

  always_comb begin
    s_ready   = !reset && (state_q == StAccum);
    accept    = s_valid && s_ready;
    slot_free = !m_valid || m_ready;
    dump_fire = !reset && (state_q == StDump) && slot_free;
    acc_en    = accept;
    acc_din   = s_data;
    acc_rst   = reset || dump_fire;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    partial_d = partial_q;
    case (state_q)
      StAccum: begin
        if (accept) begin
          count_d = count_q + 1'b1;
        end
        // A completing sample wins over a same-cycle flush: the window is full, not partial.
        if (accept && (count_q == LastCnt)) begin
          state_d   = StDump;
          partial_d = 1'b0;
        end else if (flush && (count_d != '0)) begin
          state_d   = StDump;
          partial_d = 1'b1;
        end
      end
      StDump: begin
        if (dump_fire) begin
          state_d = StAccum;
          count_d = '0;
        end
      end
      default: begin
        state_d = StAccum;
      end
    endcase
  end

  always_comb begin
    rnd_sum = $signed({acc_sum[19], acc_sum}) + Rnd;
    shifted = rnd_sum >>> LOG2N;
    if (shifted > 21'sd32767) begin
      mean_sat = 16'h7FFF;
    end else if (shifted < -21'sd32768) begin
      mean_sat = 16'h8000;
    end else begin
      mean_sat = shifted[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StAccum;
      count_q   <= '0;
      partial_q <= 1'b0;
      m_valid   <= 1'b0;
      m_data    <= 16'h0000;
      m_partial <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      partial_q <= partial_d;
      if (dump_fire) begin
        m_valid   <= 1'b1;
        m_data    <= mean_sat;
        m_partial <= partial_q;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
